// File: rtl/keycode_pkg.sv
// Shared definitions for the keycode-to-action controller: HID keycodes,
// action bit positions, FSM state types and the per-frame keycode decoder.
package keycode_pkg;

  // USB HID usage codes recognised as game actions
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_J     = 8'h0D;
  localparam logic [7:0] KC_K     = 8'h0E;

  // Bit positions inside an action mask {dash, attack, jump, right, left}
  localparam int ACT_LEFT   = 0;
  localparam int ACT_RIGHT  = 1;
  localparam int ACT_JUMP   = 2;
  localparam int ACT_ATTACK = 3;
  localparam int ACT_DASH   = 4;
  localparam int N_ACT      = 5;

  typedef logic [N_ACT-1:0] act_mask_t;

  typedef enum logic [1:0] {
    D_NONE  = 2'd0,
    D_LEFT  = 2'd1,
    D_RIGHT = 2'd2
  } dir_state_t;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_RISE = 2'd1,
    J_LOCK = 2'd2
  } jump_state_t;

  // Map four keycode bytes to an action mask. Every slot is matched
  // independently and the hits are OR-ed, so duplicates and unknown codes
  // (including the 0x00 empty slot) need no special handling.
  function automatic act_mask_t decode_keycodes(input logic [31:0] kc);
    act_mask_t  m;
    logic [7:0] b;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      b = kc[8*i +: 8];
      if (b == KC_A)                  m[ACT_LEFT]   = 1'b1;
      if (b == KC_D)                  m[ACT_RIGHT]  = 1'b1;
      if (b == KC_SPACE || b == KC_W) m[ACT_JUMP]   = 1'b1;
      if (b == KC_J)                  m[ACT_ATTACK] = 1'b1;
      if (b == KC_K)                  m[ACT_DASH]   = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/action_cooldown.sv
// One-shot trigger with a frame-counted cooldown. A press fires only when
// the counter is idle; presses during cooldown are dropped, never queued.
module action_cooldown #(
  parameter int CD_FRAMES = 20,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic reset_n,   // synchronous, active-low
  input  logic tick,      // one-clk frame evaluation strobe
  input  logic pressed,   // rising edge of the action key this frame
  output logic fire,      // one-frame trigger, held until the next tick
  output logic busy       // cooldown in progress
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_q, fire_d;

  // Next-state: fire on an accepted press, otherwise count the cooldown down
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    cnt_d  = cnt_q;
    fire_d = fire_q;
    if (tick) begin
      fire_d = 1'b0;
      if (pressed && cnt_q == '0) begin
        fire_d = 1'b1;
        cnt_d  = CNT_W'(CD_FRAMES);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      cnt_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
    end
  end

  assign fire = fire_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/keycode_action_ctrl.sv
// Frame-rate controller: samples the NIOS keycode PIO once per frame, derives
// held/pressed masks and sequences direction, variable-height jump and
// attack/dash cooldowns into outputs that are stable for a whole frame.
module keycode_action_ctrl
  import keycode_pkg::*;
#(
  parameter int JUMP_MAX_FRAMES  = 12,
  parameter int ATTACK_CD_FRAMES = 20,
  parameter int DASH_CD_FRAMES   = 45,
  parameter int CNT_W            = 6
) (
  input  logic        clk,
  input  logic        reset_n,     // synchronous, active-low
  input  logic        frame_tick,  // one-clk pulse per frame
  input  logic [31:0] keycodes,    // four HID keycode bytes, 0x00 = empty
  output logic        move_left,
  output logic        move_right,
  output logic        facing,      // 0 = left, 1 = right
  output logic        jump_start,
  output logic        jump_hold,
  output logic        attack_fire,
  output logic        dash_fire,
  output logic [4:0]  keys_held,   // {dash, attack, jump, right, left}
  output logic        update       // one-clk pulse per new output set
);

  // Sample stage
  act_mask_t cur_q, prev_q;
  logic      eval_q;     // a sampled frame waits to be evaluated
  act_mask_t pressed;

  // Control state
  dir_state_t       dir_q, dir_d;
  logic             facing_q, facing_d;
  jump_state_t      jump_q, jump_d;
  logic [CNT_W-1:0] jcnt_q, jcnt_d;
  logic             jump_start_q, jump_start_d;
  logic             jump_hold_q, jump_hold_d;
  act_mask_t        keys_held_q;
  logic             update_q;

  logic attack_busy, dash_busy;
  logic unused_busy;

  // Capture the keycodes on each tick and retire the previous frame's mask
  // when it is evaluated; back-to-back ticks therefore form two frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_q  <= '0;
      prev_q <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= frame_tick;
      if (frame_tick) cur_q  <= decode_keycodes(keycodes);
      if (eval_q)     prev_q <= cur_q;
    end
  end

  assign pressed = cur_q & ~prev_q;

  // Direction: newest press wins (LEFT on a tie); on release of the active
  // side fall back to the other side if it is still held.
  always_comb begin
    dir_d    = dir_q;
    facing_d = facing_q;
    if (eval_q) begin
      if (pressed[ACT_LEFT]) begin
        dir_d = D_LEFT;
      end else if (pressed[ACT_RIGHT]) begin
        dir_d = D_RIGHT;
      end else begin
        case (dir_q)
          D_LEFT: begin
            if (!cur_q[ACT_LEFT]) dir_d = cur_q[ACT_RIGHT] ? D_RIGHT : D_NONE;
          end
          D_RIGHT: begin
            if (!cur_q[ACT_RIGHT]) dir_d = cur_q[ACT_LEFT] ? D_LEFT : D_NONE;
          end
          default: begin
            if (cur_q[ACT_LEFT])       dir_d = D_LEFT;
            else if (cur_q[ACT_RIGHT]) dir_d = D_RIGHT;
            else                       dir_d = D_NONE;
          end
        endcase
      end
      if (dir_d == D_LEFT)       facing_d = 1'b0;
      else if (dir_d == D_RIGHT) facing_d = 1'b1;
    end
  end

  // Jump: rise while held up to JUMP_MAX_FRAMES, then lock until release so
  // a held key never re-triggers.
  always_comb begin
    jump_d       = jump_q;
    jcnt_d       = jcnt_q;
    jump_start_d = jump_start_q;
    jump_hold_d  = jump_hold_q;
    if (eval_q) begin
      jump_start_d = 1'b0;
      jump_hold_d  = 1'b0;
      case (jump_q)
        J_IDLE: begin
          if (pressed[ACT_JUMP]) begin
            jump_d       = J_RISE;
            jump_start_d = 1'b1;
            jump_hold_d  = 1'b1;
            jcnt_d       = CNT_W'(1);
          end
        end
        J_RISE: begin
          if (!cur_q[ACT_JUMP]) begin
            jump_d = J_IDLE;
            jcnt_d = '0;
          end else if (jcnt_q < CNT_W'(JUMP_MAX_FRAMES)) begin
            jcnt_d      = jcnt_q + CNT_W'(1);
            jump_hold_d = 1'b1;
          end else begin
            jump_d = J_LOCK;
            jcnt_d = '0;
          end
        end
        J_LOCK: begin
          if (!cur_q[ACT_JUMP]) jump_d = J_IDLE;
        end
        default: begin
          jump_d = J_IDLE;
          jcnt_d = '0;
        end
      endcase
    end
  end

  // Control and output registers; all of them move only on evaluation edges
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_q        <= D_NONE;
      facing_q     <= 1'b1;
      jump_q       <= J_IDLE;
      jcnt_q       <= '0;
      jump_start_q <= 1'b0;
      jump_hold_q  <= 1'b0;
      keys_held_q  <= '0;
      update_q     <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      facing_q     <= facing_d;
      jump_q       <= jump_d;
      jcnt_q       <= jcnt_d;
      jump_start_q <= jump_start_d;
      jump_hold_q  <= jump_hold_d;
      if (eval_q) keys_held_q <= cur_q;
      update_q     <= eval_q;
    end
  end

  action_cooldown #(
    .CD_FRAMES (ATTACK_CD_FRAMES),
    .CNT_W     (CNT_W)
  ) u_attack_cd (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (eval_q),
    .pressed (pressed[ACT_ATTACK]),
    .fire    (attack_fire),
    .busy    (attack_busy)
  );

  action_cooldown #(
    .CD_FRAMES (DASH_CD_FRAMES),
    .CNT_W     (CNT_W)
  ) u_dash_cd (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (eval_q),
    .pressed (pressed[ACT_DASH]),
    .fire    (dash_fire),
    .busy    (dash_busy)
  );

  // Cooldown status is not consumed by the physics side at present
  assign unused_busy = attack_busy ^ dash_busy;

  assign move_left  = (dir_q == D_LEFT);
  assign move_right = (dir_q == D_RIGHT);
  assign facing     = facing_q;
  assign jump_start = jump_start_q;
  assign jump_hold  = jump_hold_q;
  assign keys_held  = keys_held_q;
  assign update     = update_q;

endmodule

// File: tb/tb_keycode_action_ctrl.sv
// Scoreboard bench for keycode_action_ctrl: the driver pushes the expected
// output set for every frame tick, the monitor pops on each update pulse.
module tb_keycode_action_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [31:0] keycodes;
  logic        move_left, move_right, facing, jump_start, jump_hold;
  logic        attack_fire, dash_fire, update;
  logic [4:0]  keys_held;
  logic [11:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [11:0] vec;
    int          tick_cyc;
    string       name;
  } exp_t;

  exp_t q[$];

  keycode_action_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .keycodes    (keycodes),
    .move_left   (move_left),
    .move_right  (move_right),
    .facing      (facing),
    .jump_start  (jump_start),
    .jump_hold   (jump_hold),
    .attack_fire (attack_fire),
    .dash_fire   (dash_fire),
    .keys_held   (keys_held),
    .update      (update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {move_left, move_right, facing, jump_start, jump_hold,
                attack_fire, dash_fire, keys_held};

  function automatic logic [11:0] ev(input logic ml, input logic mr,
                                     input logic f, input logic js,
                                     input logic jh, input logic af,
                                     input logic df, input logic [4:0] h);
    return {ml, mr, f, js, jh, af, df, h};
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] e, input int tc, input string name);
    exp_t x;
    x.vec      = e;
    x.tick_cyc = tc;
    x.name     = name;
    q.push_back(x);
  endtask

  // One frame: tick with the given keycodes, then confirm the outputs hold
  task automatic frame(input logic [31:0] kc, input logic [11:0] e,
                       input string name);
    @(negedge clk);
    keycodes   = kc;
    frame_tick = 1'b1;
    push(e, cyc + 1, name);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_hold"}, 16'(obs), 16'(e));
    check({name, "_updlow"}, 16'(update), 16'd0);
  endtask

  // Two ticks in consecutive clock cycles
  task automatic frame2(input logic [31:0] kc1, input logic [11:0] e1,
                        input string n1, input logic [31:0] kc2,
                        input logic [11:0] e2, input string n2);
    @(negedge clk);
    keycodes   = kc1;
    frame_tick = 1'b1;
    push(e1, cyc + 1, n1);
    @(negedge clk);
    keycodes = kc2;
    push(e2, cyc + 1, n2);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check({n2, "_hold"}, 16'(obs), 16'(e2));
  endtask

  // Monitor: every update pulse must match the oldest outstanding frame
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && update === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_update: got update at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          check({e.name, "_lat"}, 16'(cyc - e.tick_cyc), 16'd1);
          check(e.name, 16'(obs), 16'(e.vec));
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    keycodes   = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outs", 16'(obs), 16'(ev(0,0,1,0,0,0,0,5'b00000)));
    check("reset_update", 16'(update), 16'd0);
    reset_n = 1'b1;

    // Idle frames
    for (int i = 0; i < 3; i++)
      frame(32'h0, ev(0,0,1,0,0,0,0,5'b00000), $sformatf("idle%0d", i));

    // Last pressed wins
    frame(32'h0000_0004, ev(1,0,0,0,0,0,0,5'b00001), "dir_a");
    frame(32'h0000_0704, ev(0,1,1,0,0,0,0,5'b00011), "dir_ad");
    frame(32'h0,         ev(0,0,1,0,0,0,0,5'b00000), "dir_clr1");

    // Simultaneous press: LEFT wins; facing holds in D_NONE
    frame(32'h0000_0704, ev(1,0,0,0,0,0,0,5'b00011), "dir_both");
    frame(32'h0,         ev(0,0,0,0,0,0,0,5'b00000), "dir_clr2");

    // Release of active side falls back to the held side
    frame(32'h0000_0704, ev(1,0,0,0,0,0,0,5'b00011), "dir_both2");
    frame(32'h0000_0700, ev(0,1,1,0,0,0,0,5'b00010), "dir_fallback");
    frame(32'h0,         ev(0,0,1,0,0,0,0,5'b00000), "dir_clr3");

    // Duplicates and unknown codes
    frame(32'h0499_0400, ev(1,0,0,0,0,0,0,5'b00001), "dec_dup");
    frame(32'h0,         ev(0,0,0,0,0,0,0,5'b00000), "dec_clr");

    // Back-to-back ticks are two frames
    frame2(32'h0000_0007, ev(0,1,1,0,0,0,0,5'b00010), "b2b_1",
           32'h0000_0004, ev(1,0,0,0,0,0,0,5'b00001), "b2b_2");
    frame(32'h0,         ev(0,0,0,0,0,0,0,5'b00000), "b2b_clr");

    // W is also jump; early release ends the ascent
    frame(32'h0000_001A, ev(0,0,0,1,1,0,0,5'b00100), "jump_w");
    frame(32'h0,         ev(0,0,0,0,0,0,0,5'b00000), "jump_w_rel");

    // Held Space for 20 frames: hold for frames 1..12, then locked
    for (int i = 1; i <= 20; i++)
      frame(32'h0000_002C,
            ev(0,0,0, logic'(i == 1), logic'(i <= 12), 0,0, 5'b00100),
            $sformatf("jump_f%0d", i));
    frame(32'h0,         ev(0,0,0,0,0,0,0,5'b00000), "jump_rel");
    frame(32'h0000_002C, ev(0,0,0,1,1,0,0,5'b00100), "jump_again");
    frame(32'h0,         ev(0,0,0,0,0,0,0,5'b00000), "jump_rel2");

    // Attack cooldown: presses on frames 0, 5, 21; fires on 0 and 21
    for (int i = 0; i <= 22; i++) begin
      logic p;
      p = (i == 0 || i == 5 || i == 21);
      frame(p ? 32'h0000_000D : 32'h0,
            ev(0,0,0,0,0, logic'(i == 0 || i == 21), 0, p ? 5'b01000 : 5'b00000),
            $sformatf("atk_f%0d", i));
    end

    // Reset mid-jump (jcnt = 5) with dash cooling down
    frame(32'h0000_000E, ev(0,0,0,0,0,0,1,5'b10000), "dash_fire1");
    frame(32'h0000_002C, ev(0,0,0,1,1,0,0,5'b00100), "rst_jump_f1");
    for (int i = 2; i <= 5; i++)
      frame(32'h0000_002C, ev(0,0,0,0,1,0,0,5'b00100), $sformatf("rst_jump_f%0d", i));
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_outs", 16'(obs), 16'(ev(0,0,1,0,0,0,0,5'b00000)));
    check("midrst_update", 16'(update), 16'd0);
    reset_n = 1'b1;
    frame(32'h0000_000E, ev(0,0,1,0,0,0,1,5'b10000), "dash_after_rst");
    frame(32'h0000_000E, ev(0,0,1,0,0,0,0,5'b10000), "dash_held");

    repeat (5) @(negedge clk);
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keycode_action_ctrl.md
Name: keycode_action_ctrl

Overview:
- Frame-rate controller between the keycode PIO output ports (up to four USB HID keycode bytes written by the NIOS) and the player-physics logic.
- Once per frame it samples the keycodes and decodes them into per-action held, pressed and released masks.
- It resolves left/right conflicts with last-pressed-wins.
- It sequences variable-height jumps, and attack/dash cooldowns, into frame-stable action outputs.

Parameters:
- JUMP_MAX_FRAMES, 12, maximum frames jump_hold stays asserted for one jump.
- ATTACK_CD_FRAMES, 20, frames after an attack before the next attack is accepted.
- DASH_CD_FRAMES, 45, frames after a dash before the next dash is accepted.
- CNT_W, 6, width of the jump and cooldown counters; must hold max(JUMP_MAX_FRAMES, ATTACK_CD_FRAMES, DASH_CD_FRAMES).

Ports:
- clk  in  1  system clock (single clock domain).
- reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-clk pulse per frame (vsync edge).
- keycodes  in  32  four keycode bytes; byte 0 = [7:0]; 0x00 = empty slot.
- move_left  out  1  horizontal intent left.
- move_right  out  1  horizontal intent right; never both 1.
- facing  out  1  0 = left, 1 = right; holds the last nonzero direction.
- jump_start  out  1  high for exactly one frame when a jump begins.
- jump_hold  out  1  jump ascent sustain.
- attack_fire  out  1  one-frame attack trigger.
- dash_fire  out  1  one-frame dash trigger.
- keys_held  out  5  decoded held mask {dash, attack, jump, right, left}.
- update  out  1  one-clk pulse marking a new output set.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - All outputs go to 0, except facing = 1.
  - prev mask, counters and both FSMs clear.
  - A reset asserted mid-jump or mid-cooldown aborts it with no residual pulse.
- Decode (combinational from keycodes):
  - A byte sets an action bit when it equals that action's code: LEFT 0x04 (A), RIGHT 0x07 (D), JUMP 0x2C (Space) or 0x1A (W), ATTACK 0x0D (J), DASH 0x0E (K).
  - Multiple bytes OR together; duplicate bytes are harmless; unknown codes are ignored.
- Latency and update timing:
  - On a clk edge with frame_tick = 1: cur mask is registered, pressed = cur & ~prev, released = prev & ~cur, then prev <= cur.
  - All outputs update on the following clk edge (latency 2 clk from the tick) and hold until the next update.
  - update pulses on that same edge.
  - Keycode changes between ticks are invisible.
- Direction FSM, states D_NONE, D_LEFT, D_RIGHT. Transitions are evaluated at each update:
  - Newly pressed direction wins.
  - If both are pressed in the same frame, LEFT wins.
  - If the active direction is released while the other is held, switch to the other.
  - If neither is held, go to D_NONE.
  - move_left/move_right are one-hot from the state; facing follows D_LEFT/D_RIGHT and is unchanged in D_NONE.
- Jump FSM, states J_IDLE, J_RISE, J_LOCK:
  - J_IDLE with jump pressed → J_RISE: jump_start = 1, jump_hold = 1, jcnt = 1.
  - J_RISE with jump still held and jcnt < JUMP_MAX_FRAMES: stay, jcnt++, jump_hold = 1.
  - J_RISE with jump released: → J_IDLE, jump_hold = 0.
  - J_RISE with jcnt reaching JUMP_MAX_FRAMES while held: → J_LOCK, jump_hold = 0.
  - J_LOCK: wait for release, then → J_IDLE.
  - A held key never auto-repeats jumps.
  - jump_start is only possible from J_IDLE.
  - jump_hold is high for at most JUMP_MAX_FRAMES consecutive updates.
- Attack and dash (identical structure, independent counters):
  - pressed & cnt == 0: fire = 1 for that frame, cnt <= CD_FRAMES.
  - cnt > 0: cnt decrements once per update, saturating at 0.
  - Presses while cnt > 0 are dropped, not queued.
  - Attack and dash may fire in the same frame.
- Simultaneous events:
  - A press and release of the same key between two ticks is lost by design.
  - frame_tick asserted in consecutive clk cycles is treated as two frames.

Decomposition:
- Package keycode_pkg holds:
  - the keycode constants (KC_A, KC_D, KC_SPACE, KC_W, KC_J, KC_K);
  - action bit indices (ACT_LEFT … ACT_DASH);
  - the dir_state_t and jump_state_t enums.
- One sub-module is natural: action_cooldown (pressed, tick → fire, busy), parameterised by CD_FRAMES and instantiated twice.

Test Plan:
- Reset, then keycodes = 0x00000000 with 3 ticks → all outputs 0, facing = 1, update pulses 2 clk after each tick.
- keycodes = 0x00000004, tick; then 0x00000704, tick → move_left = 1; then move_right = 1, move_left = 0 (last pressed wins), facing = 1.
- keycodes = 0x00000704 pressed together from idle, tick → move_left = 1, facing = 0; clear keycodes, tick → both 0, facing stays 0.
- Hold 0x2C for 20 ticks → jump_start = 1 on frame 1 only; jump_hold = 1 for frames 1–12, 0 for frames 13–20; no second jump_start until released and re-pressed.
- Press 0x0D on frame 0, release, press again on frame 5 and frame 21 → attack_fire on frames 0 and 21 only.
- Assert reset_n = 0 during J_RISE at jcnt = 5 with dash cooldown active → next update: jump_hold = 0, an immediate 0x0E press fires dash_fire.
